fetch_pc_unit: RTL

- Instruction-fetch / program-counter stage directly upstream of the 8-bit ALU.
- Holds the PC and produces the instruction-memory address.
- Consumes the ALU zero flag to resolve bneg (opcode 010), and detects stp (opcode 000) to halt.
- Runs the Req/Ack start-done handshake with the test harness.

---
 rtl/fetch_pc_unit_pkg.sv | 22 ++
 rtl/fetch_pc_unit_if.sv | 26 ++
 rtl/fetch_pc_unit_branch_lut.sv | 22 ++
 rtl/fetch_pc_unit.sv | 102 ++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared opcode, state and sizing definitions for the fetch/PC stage.
// Optional CYCLE_COUNT_EN build adds a RUN-cycle counter in the top.
package fetch_pc_unit_pkg;

    localparam int PC_W_DEF = 10;

    localparam logic [2:0] OP_STP  = 3'b000;
    localparam logic [2:0] OP_SHF  = 3'b001;
    localparam logic [2:0] OP_BNEG = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_ST   = 3'b110;
    localparam logic [2:0] OP_LD   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Harness/ROM/ALU side bundle of the fetch stage.
// master = harness side, slave = fetch_pc_unit.
interface fetch_pc_unit_if
    import fetch_pc_unit_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
);
    logic            Req;
    logic [8:0]      Instr;
    logic            Zero;
    logic            Stall;
    logic [PC_W-1:0] PC;
    logic            Running;
    logic            Ack;
    logic [15:0]     Cycle_cnt;

    modport master (
        output Req, Instr, Zero, Stall,
        input  PC, Running, Ack, Cycle_cnt
    );

    modport slave (
        input  Req, Instr, Zero, Stall,
        output PC, Running, Ack, Cycle_cnt
    );
endinterface

// File: rtl/fetch_pc_unit_branch_lut.sv
// Absolute branch-target table for bneg; regenerated per program.
// Unlisted indices resolve to address 0.
module fetch_pc_unit_branch_lut
    import fetch_pc_unit_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int LUT_IDX_W = 5
) (
    input  logic [LUT_IDX_W-1:0] idx,
    output logic [PC_W-1:0]      target
);
    always_comb begin
        target = '0;
        case (int'(idx))
            1:       target = PC_W'(12);
            3:       target = PC_W'(40);
            4:       target = PC_W'(5);
            7:       target = PC_W'(100);
            default: target = '0;
        endcase
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch/PC stage: PC sequencing, bneg resolution, stp halt, Req/Ack.
// Define CYCLE_COUNT_EN to build the saturating RUN-cycle counter.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int              PC_W       = PC_W_DEF,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter int              LUT_IDX_W  = 5
) (
    input  logic          CLK,
    input  logic          Reset,
    fetch_pc_unit_if.slave bus
);
    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] lut_target;
    logic            running;
    logic            ack;
    logic [2:0]      opcode;
    logic            is_stp;
    logic            take_branch;

    assign opcode      = bus.Instr[8:6];
    assign is_stp      = (opcode == OP_STP);
    assign take_branch = (opcode == OP_BNEG) && bus.Zero;

    fetch_pc_unit_branch_lut #(
        .PC_W      (PC_W),
        .LUT_IDX_W (LUT_IDX_W)
    ) u_lut (
        .idx    (bus.Instr[LUT_IDX_W-1:0]),
        .target (lut_target)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= IDLE;
            pc      <= '0;
            running <= 1'b0;
            ack     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.Req) begin
                        state   <= RUN;
                        pc      <= START_ADDR;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    // Stall freezes everything, including halt/branch decode
                    if (!bus.Stall) begin
                        unique case (1'b1)
                            is_stp: begin
                                state   <= DONE;
                                running <= 1'b0;
                                ack     <= 1'b1;
                            end
                            take_branch: pc <= lut_target;
                            default:     pc <= pc + 1'b1;
                        endcase
                    end
                end
                DONE: begin
                    if (bus.Req) begin
                        state   <= RUN;
                        pc      <= START_ADDR;
                        running <= 1'b1;
                        ack     <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    ack     <= 1'b0;
                end
            endcase
        end
    end

`ifdef CYCLE_COUNT_EN
    logic [15:0] cycle_cnt;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cycle_cnt <= '0;
        end else if ((state == IDLE || state == DONE) && bus.Req) begin
            cycle_cnt <= '0;
        end else if (state == RUN && cycle_cnt != 16'hFFFF) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

    assign bus.Cycle_cnt = cycle_cnt;
`else
    assign bus.Cycle_cnt = '0;
`endif

    assign bus.PC      = pc;
    assign bus.Running = running;
    assign bus.Ack     = ack;
endmodule
